// File: rtl/inst_rom_loader.sv
// Byte-serial program loader and zero-latency instruction ROM; holds the core while loading.
// Fetch is combinational; load_ready is high only in LOAD, one byte accepted per cycle.
module inst_rom_loader #(
   parameter int ADDR_WIDTH = 10
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic                  load_start,
   input  logic                  load_valid,
   input  logic [7:0]            load_byte,
   input  logic                  load_last,
   output logic                  load_ready,
   input  logic                  rom_chip_enable,
   input  logic [31:0]           rom_addr,
   output logic [31:0]           rom_data,
   output logic                  cpu_hold,
   output logic [ADDR_WIDTH:0]   loaded_words,
   output logic                  load_error
);

   localparam int DEPTH = 1 << ADDR_WIDTH;
   localparam logic [ADDR_WIDTH:0] WORD_MAX = {1'b1, {ADDR_WIDTH{1'b0}}};

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_LOAD = 2'd1;
   localparam logic [1:0] ST_RUN  = 2'd2;

   logic [1:0]            state;
   logic [1:0]            byte_cnt;
   logic [ADDR_WIDTH:0]   word_cnt;
   logic [31:0]           asm_word;
   logic [31:0]           word_next;
   logic [31:0]           mem [DEPTH];

   logic                  accept;
   logic                  complete;
   logic                  overflow;
   logic                  wr_en;

   logic [ADDR_WIDTH-1:0] fetch_idx;
   logic                  addr_in_range;
   logic                  fetch_hit;

   assign accept   = load_valid && load_ready && !load_start;
   assign complete = accept && ((byte_cnt == 2'd3) || load_last);
   assign overflow = complete && (word_cnt == WORD_MAX);
   assign wr_en    = complete && !overflow;

   // Assembly register is cleared after every commit, so unfilled low bytes read as zero.
   always_comb begin
      word_next = asm_word;
      case (byte_cnt)
         2'd0:    word_next[31:24] = load_byte;
         2'd1:    word_next[23:16] = load_byte;
         2'd2:    word_next[15:8]  = load_byte;
         default: word_next[7:0]   = load_byte;
      endcase
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state      <= ST_IDLE;
         load_ready <= 1'b0;
         cpu_hold   <= 1'b1;
         load_error <= 1'b0;
         byte_cnt   <= 2'd0;
         word_cnt   <= '0;
         asm_word   <= 32'h0;
      end else if (load_start) begin
         state      <= ST_LOAD;
         load_ready <= 1'b1;
         cpu_hold   <= 1'b1;
         load_error <= 1'b0;
         byte_cnt   <= 2'd0;
         word_cnt   <= '0;
         asm_word   <= 32'h0;
      end else if (accept) begin
         if (complete) begin
            asm_word <= 32'h0;
            byte_cnt <= 2'd0;
            if (overflow) begin
               load_error <= 1'b1;
            end else begin
               word_cnt <= word_cnt + 1'b1;
            end
            if (load_last) begin
               load_ready <= 1'b0;
               if (!load_error && !overflow) begin
                  state    <= ST_RUN;
                  cpu_hold <= 1'b0;
               end else begin
                  state <= ST_IDLE;
               end
            end
         end else begin
            asm_word <= word_next;
            byte_cnt <= byte_cnt + 2'd1;
         end
      end
   end

   // Storage has no reset: contents persist, visibility is gated by loaded_words.
   always_ff @(posedge clock) begin
      if (wr_en) begin
         mem[word_cnt[ADDR_WIDTH-1:0]] <= word_next;
      end
   end

   assign loaded_words  = word_cnt;
   assign fetch_idx     = rom_addr[ADDR_WIDTH+1:2];
   assign addr_in_range = (rom_addr >> (ADDR_WIDTH + 2)) == 32'h0;
   assign fetch_hit     = (state == ST_RUN) && rom_chip_enable && addr_in_range &&
                          ({1'b0, fetch_idx} < word_cnt);
   assign rom_data      = fetch_hit ? mem[fetch_idx] : 32'h0;

endmodule

// File: tb/tb_inst_rom_loader.sv
// Bench for inst_rom_loader: byte-queue reference model checked every cycle, plus directed scenarios.
module tb_inst_rom_loader;
   localparam int AW    = 2;
   localparam int DEPTH = 1 << AW;

   logic          clock = 1'b0;
   logic          reset = 1'b0;
   logic          load_start = 1'b0;
   logic          load_valid = 1'b0;
   logic [7:0]    load_byte = 8'h0;
   logic          load_last = 1'b0;
   logic          rom_chip_enable = 1'b0;
   logic [31:0]   rom_addr = 32'h0;
   logic          load_ready;
   logic          cpu_hold;
   logic          load_error;
   logic [AW:0]   loaded_words;
   logic [31:0]   rom_data;

   int checks = 0;
   int errors = 0;
   bit chk_en = 1'b0;
   bit rnd_fetch = 1'b0;

   // Reference model: 0 idle, 1 load, 2 run; bytes accepted by the current load.
   int         mstate = 0;
   logic [7:0] mq[$];
   bit         m_last = 1'b0;

   always #5 clock = ~clock;

   inst_rom_loader #(.ADDR_WIDTH(AW)) dut (
      .clock(clock), .reset(reset),
      .load_start(load_start), .load_valid(load_valid), .load_byte(load_byte),
      .load_last(load_last), .load_ready(load_ready),
      .rom_chip_enable(rom_chip_enable), .rom_addr(rom_addr), .rom_data(rom_data),
      .cpu_hold(cpu_hold), .loaded_words(loaded_words), .load_error(load_error)
   );

   function automatic int commits();
      int n = mq.size();
      return m_last ? (n + 3) / 4 : n / 4;
   endfunction

   function automatic int exp_loaded();
      int c = commits();
      return (c > DEPTH) ? DEPTH : c;
   endfunction

   function automatic logic [31:0] exp_word(input int idx);
      logic [31:0] w = 32'h0;
      for (int k = 0; k < 4; k++) begin
         int j = 4 * idx + k;
         if (j < mq.size()) w[31 - 8 * k -: 8] = mq[j];
      end
      return w;
   endfunction

   function automatic logic [31:0] exp_rom();
      int idx = int'(rom_addr[AW+1:2]);
      if (mstate != 2 || !rom_chip_enable || (rom_addr >> (AW + 2)) != 32'h0 || idx >= exp_loaded())
         return 32'h0;
      return exp_word(idx);
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   always @(posedge clock or negedge reset) begin
      if (!reset) begin
         mstate = 0; mq.delete(); m_last = 1'b0;
      end else if (load_start) begin
         mstate = 1; mq.delete(); m_last = 1'b0;
      end else if (mstate == 1 && load_valid) begin
         mq.push_back(load_byte);
         if (load_last) begin
            m_last = 1'b1;
            mstate = (commits() > DEPTH) ? 0 : 2;
         end
      end
   end

   always @(negedge clock) begin
      #2;
      if (chk_en) begin
         check("model_load_ready", 32'(load_ready), 32'(mstate == 1));
         check("model_cpu_hold", 32'(cpu_hold), 32'(mstate != 2));
         check("model_loaded_words", 32'(loaded_words), 32'(exp_loaded()));
         check("model_load_error", 32'(load_error), 32'(commits() > DEPTH));
         check("model_rom_data", rom_data, exp_rom());
      end
   end

   task automatic drive(input logic st, input logic v, input logic [7:0] b, input logic l);
      @(negedge clock);
      load_start = st; load_valid = v; load_byte = b; load_last = l;
      if (rnd_fetch) begin
         rom_chip_enable = ($urandom_range(0, 7) != 0);
         rom_addr = ($urandom_range(0, 7) == 0) ? $urandom : 32'($urandom_range(0, 23));
      end
   endtask

   task automatic send(input logic [7:0] b, input logic l);
      drive(1'b0, 1'b1, b, l);
   endtask

   task automatic idle();
      drive(1'b0, 1'b0, 8'h0, 1'b0);
   endtask

   task automatic fetch_chk(input string name, input logic [31:0] addr, input logic [31:0] exp);
      @(negedge clock);
      load_start = 1'b0; load_valid = 1'b0; load_last = 1'b0;
      rom_addr = addr; rom_chip_enable = 1'b1;
      #3;
      check(name, rom_data, exp);
   endtask

   initial begin
      logic [7:0] basic [8];
      int len;
      basic = '{8'h3C, 8'h01, 8'h12, 8'h34, 8'h34, 8'h21, 8'h00, 8'h05};

      repeat (3) @(negedge clock);
      reset = 1'b1;
      chk_en = 1'b1;
      fetch_chk("reset_rom_data", 32'h0, 32'h0);
      check("reset_load_ready", 32'(load_ready), 32'h0);
      check("reset_cpu_hold", 32'(cpu_hold), 32'h1);
      check("reset_loaded_words", 32'(loaded_words), 32'h0);
      check("reset_load_error", 32'(load_error), 32'h0);

      // Basic load and fetch
      drive(1'b1, 1'b0, 8'h0, 1'b0);
      for (int i = 0; i < 8; i++) send(basic[i], i == 7);
      idle();
      #3;
      check("basic_loaded_words", 32'(loaded_words), 32'd2);
      check("basic_cpu_hold", 32'(cpu_hold), 32'h0);
      fetch_chk("basic_addr0", 32'h0, 32'h3C011234);
      fetch_chk("basic_addr4", 32'h4, 32'h34210005);
      fetch_chk("basic_addr8", 32'h8, 32'h0);
      fetch_chk("basic_addr5_low_bits", 32'h5, 32'h34210005);

      // Partial final word
      drive(1'b1, 1'b0, 8'h0, 1'b0);
      send(8'hAA, 1'b0);
      send(8'hBB, 1'b1);
      idle();
      #3;
      check("partial_loaded_words", 32'(loaded_words), 32'd1);
      check("partial_cpu_hold", 32'(cpu_hold), 32'h0);
      fetch_chk("partial_addr0", 32'h0, 32'hAABB0000);
      fetch_chk("partial_addr4_hidden", 32'h4, 32'h0);

      // Overflow: 17 bytes into a 4-word store
      drive(1'b1, 1'b0, 8'h0, 1'b0);
      for (int i = 0; i < 17; i++) send(8'(i + 1), i == 16);
      idle();
      #3;
      check("ovf_load_error", 32'(load_error), 32'h1);
      check("ovf_loaded_words", 32'(loaded_words), 32'd4);
      check("ovf_cpu_hold", 32'(cpu_hold), 32'h1);
      check("ovf_load_ready", 32'(load_ready), 32'h0);
      fetch_chk("ovf_addr0", 32'h0, 32'h0);
      fetch_chk("ovf_addr12", 32'hC, 32'h0);

      // Start versus valid collision
      drive(1'b1, 1'b0, 8'h0, 1'b0);
      send(8'h01, 1'b0);
      send(8'h02, 1'b0);
      drive(1'b1, 1'b1, 8'hFF, 1'b0);
      send(8'h11, 1'b0);
      #3;
      check("coll_loaded_words", 32'(loaded_words), 32'd0);
      check("coll_load_error", 32'(load_error), 32'h0);
      send(8'h22, 1'b0);
      send(8'h33, 1'b0);
      send(8'h44, 1'b1);
      idle();
      #3;
      check("coll_loaded_after", 32'(loaded_words), 32'd1);
      fetch_chk("coll_addr0", 32'h0, 32'h11223344);

      // Reset mid-load
      drive(1'b1, 1'b0, 8'h0, 1'b0);
      send(8'hA1, 1'b0);
      send(8'hA2, 1'b0);
      send(8'hA3, 1'b0);
      @(negedge clock);
      load_valid = 1'b0;
      reset = 1'b0;
      #1;
      check("rst_cpu_hold", 32'(cpu_hold), 32'h1);
      check("rst_load_ready", 32'(load_ready), 32'h0);
      check("rst_loaded_words", 32'(loaded_words), 32'h0);
      @(negedge clock);
      reset = 1'b1;
      fetch_chk("rst_addr0", 32'h0, 32'h0);
      fetch_chk("rst_addr4", 32'h4, 32'h0);

      // Fetch gating in RUN and reload from RUN
      drive(1'b1, 1'b0, 8'h0, 1'b0);
      send(8'h12, 1'b0);
      send(8'h34, 1'b0);
      send(8'h56, 1'b0);
      send(8'h78, 1'b1);
      fetch_chk("gate_enabled", 32'h0, 32'h12345678);
      @(negedge clock);
      rom_chip_enable = 1'b0;
      #3;
      check("gate_ce_low", rom_data, 32'h0);
      fetch_chk("gate_high_addr", 32'h0001_0000, 32'h0);
      drive(1'b1, 1'b0, 8'h0, 1'b0);
      idle();
      #3;
      check("reload_cpu_hold", 32'(cpu_hold), 32'h1);
      check("reload_load_ready", 32'(load_ready), 32'h1);
      send(8'h9A, 1'b1);
      idle();
      #3;
      check("reload_run", 32'(cpu_hold), 32'h0);

      // Randomized loads against the model
      rnd_fetch = 1'b1;
      for (int n = 0; n < 60; n++) begin
         if ($urandom_range(0, 7) == 0)
            for (int k = 0; k < 3; k++) send(8'($urandom), $urandom_range(0, 1) == 1);
         drive(1'b1, ($urandom_range(0, 3) == 0), 8'($urandom), 1'b0);
         len = $urandom_range(1, 20);
         for (int i = 0; i < len; i++) begin
            while ($urandom_range(0, 3) == 0) idle();
            if ($urandom_range(0, 31) == 0) drive(1'b1, 1'b1, 8'($urandom), 1'b0);
            send(8'($urandom), i == len - 1);
         end
         repeat ($urandom_range(3, 8)) idle();
      end

      rnd_fetch = 1'b0;
      idle();
      @(negedge clock);
      chk_en = 1'b0;
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
